// File: rtl/cl_cfg_reg_slv.sv
// Fixed-latency cfg bus register responder: CTRL, STATUS, SCRATCH, ID and an optional 64-bit counter.
// Define CL_CFG_REG_SLV_CNT_EN to build the cycle counter, its high-word shadow and CTRL[1:0].
module cl_cfg_reg_slv #(
  parameter int unsigned ACK_DLY  = 2,
  parameter logic [31:0] ID_VALUE = 32'hC0FF_EE01
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  output logic        cnt_en_o,
  output logic [31:0] scratch_o
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [5:0] OFS_CTRL    = 6'd0;
  localparam logic [5:0] OFS_STATUS  = 6'd1;
  localparam logic [5:0] OFS_SCRATCH = 6'd2;
  localparam logic [5:0] OFS_CNT_LO  = 6'd3;
  localparam logic [5:0] OFS_CNT_HI  = 6'd4;
  localparam logic [5:0] OFS_ID      = 6'd5;
  localparam logic [31:0] RD_UNMAPPED = 32'hDEAD_BEEF;
  localparam logic [3:0] DLY_LOAD    = 4'(ACK_DLY - 1);

  state_t      state_q, state_d;
  logic [3:0]  dly_q, dly_d;
  logic [5:0]  ofs;
  logic        ack_now, open, req_any, accept, wr_acc, rd_acc, ovl_evt;
  logic [7:0]  ovl_err;
  logic [31:0] rd_mux;
  logic        rd_pend_p1;
  logic [31:0] rd_hold_p1;
  logic        unused_addr_bits;

  assign ofs              = cfg_addr[7:2];
  assign unused_addr_bits = ^{cfg_addr[31:8], cfg_addr[1:0]};

  // The ack cycle doubles as an idle cycle, so back-to-back requests lose nothing.
  assign ack_now = (state_q == ST_WAIT) && (dly_q == 4'd0);
  assign open    = (state_q == ST_IDLE) || ack_now;
  assign req_any = cfg_wr | cfg_rd;
  assign accept  = open & req_any;
  assign wr_acc  = accept & cfg_wr;
  assign rd_acc  = accept & cfg_rd & ~cfg_wr;
  assign ovl_evt = (req_any & ~open) | (accept & cfg_wr & cfg_rd);
  assign cfg_ack = ack_now;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= ST_IDLE;
      dly_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          dly_d   = DLY_LOAD;
        end
      end
      ST_WAIT: begin
        if (dly_q != 4'd0) begin
          dly_d = dly_q - 4'd1;
        end else if (accept) begin
          dly_d = DLY_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CL_CFG_REG_SLV_CNT_EN
  logic [63:0] cnt;
  logic [31:0] cnt_shadow;
  logic        cnt_en;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt        <= 64'd0;
      cnt_shadow <= 32'd0;
      cnt_en     <= 1'b0;
    end else begin
      if (wr_acc && ofs == OFS_CTRL) begin
        cnt_en <= cfg_wdata[0];
      end
      // Clear wins over increment on the write edge.
      if (wr_acc && ofs == OFS_CTRL && cfg_wdata[1]) begin
        cnt <= 64'd0;
      end else if (cnt_en) begin
        cnt <= cnt + 64'd1;
      end
      if (rd_acc && ofs == OFS_CNT_LO) begin
        cnt_shadow <= cnt[63:32];
      end
    end
  end

  assign cnt_en_o = cnt_en;
`else
  assign cnt_en_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      scratch_o <= 32'd0;
      ovl_err   <= 8'd0;
    end else begin
      if (wr_acc && ofs == OFS_SCRATCH) begin
        scratch_o <= cfg_wdata;
      end
      if (wr_acc && ofs == OFS_STATUS) begin
        ovl_err <= 8'd0;
      end else if (ovl_evt && ovl_err != 8'hFF) begin
        ovl_err <= ovl_err + 8'd1;
      end
    end
  end

  always_comb begin
    rd_mux = RD_UNMAPPED;
    case (ofs)
`ifdef CL_CFG_REG_SLV_CNT_EN
      OFS_CTRL:    rd_mux = {31'd0, cnt_en};
      OFS_CNT_LO:  rd_mux = cnt[31:0];
      OFS_CNT_HI:  rd_mux = cnt_shadow;
`else
      OFS_CTRL:    rd_mux = 32'd0;
`endif
      OFS_STATUS:  rd_mux = {16'd0, ovl_err, 8'd0};
      OFS_SCRATCH: rd_mux = scratch_o;
      OFS_ID:      rd_mux = ID_VALUE;
      default:     rd_mux = RD_UNMAPPED;
    endcase
  end

  // Stage 1: read data sampled with the request.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rd_pend_p1 <= 1'b0;
    end else if (accept) begin
      rd_pend_p1 <= rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_hold_p1 <= rd_mux;
    end
  end

  // Stage 2: read data presented in the ack cycle and held after it.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cfg_rdata <= 32'd0;
    end else if (rd_acc && ACK_DLY == 1) begin
      cfg_rdata <= rd_mux;
    end else if (state_q == ST_WAIT && dly_q == 4'd1 && rd_pend_p1) begin
      cfg_rdata <= rd_hold_p1;
    end
  end

endmodule

// File: doc/cl_cfg_reg_slv.md
# cl_cfg_reg_slv

Register-file responder for one 256-byte cfg bus window driven by the OCL slave front end. It accepts single-cycle `wr`/`rd` request pulses and returns a single-cycle `ack` after a programmable fixed latency, with read data. It holds a control register, a scratch register, an ID register and an optional 64-bit cycle counter with an atomic high-word snapshot. It is the target end of a cfg bus and sits in the CL next to the logic it controls.

## Interface
Parameters:
- `ACK_DLY`, 2: cycles from request sample to `cfg_ack`; legal range 1..15.
- `ID_VALUE`, 32'hC0FF_EE01: value returned by the ID register.

Ports:
- `clk` input 1: sole clock.
- `sync_rst` input 1: synchronous, active-high reset.
- `cfg_addr` input 32: request address; only bits [7:2] are decoded.
- `cfg_wdata` input 32: write data, sampled with `cfg_wr`.
- `cfg_wr` input 1: one-cycle write request pulse.
- `cfg_rd` input 1: one-cycle read request pulse.
- `cfg_ack` output 1: one-cycle completion pulse.
- `cfg_rdata` output 32: read data; valid in the `cfg_ack` cycle and held until the next ack.
- `cnt_en_o` output 1: CTRL[0], for fabric use.
- `scratch_o` output 32: current SCRATCH value.

## Operation
- Register map by word offset `cfg_addr[7:2]`:
  - 0x00 CTRL (RW): [0] cnt_en; [1] cnt_clr, write-1 pulse that always reads 0; other bits read 0.
  - 0x04 STATUS (RO): [0] busy, always reads 0 because reads sample while idle; [15:8] ovl_err, a saturating count of overlapping or colliding requests.
  - 0x08 SCRATCH (RW, full word).
  - 0x0C CNT_LO (RO): returns counter[31:0] and, in the same cycle, copies counter[63:32] into the shadow register.
  - 0x10 CNT_HI (RO): returns the shadow register.
  - 0x14 ID (RO): returns `ID_VALUE`.
  - Any other offset: reads return 32'hDEAD_BEEF; writes are ignored. The request is still acked.
- Writes to RO registers are ignored and still acked.
- States:
  - IDLE: on `cfg_wr` or `cfg_rd`, go to WAIT and load the delay counter with `ACK_DLY`-1.
  - WAIT: decrement the delay counter each cycle. At zero, pulse `cfg_ack` and return to IDLE in the same cycle.
- A request is only accepted in IDLE.
- Any `cfg_wr`/`cfg_rd` seen in WAIT is dropped and increments ovl_err. The in-flight ack is unaffected.
- If `cfg_wr` and `cfg_rd` are both asserted in one cycle, the write is serviced, the read is dropped and ovl_err increments.
- ovl_err saturates at 8'hFF. Writing STATUS clears it to 0 (write data ignored).
- The counter is 64 bits and increments by 1 per cycle while cnt_en=1. It wraps from 2^64-1 to 0.
- cnt_clr zeroes the counter at T+1 and takes priority over the increment in that cycle.

## Timing
- Request sampled at edge T.
- Write effects, including `cnt_en_o`, `scratch_o` and counter clear, are visible from cycle T+1.
- Read data reflects register state at cycle T and is captured into a holding register.
- The CNT_LO read and the shadow update happen on the same edge.
- `cfg_ack` is high exactly in cycle T+`ACK_DLY`, for one cycle. `cfg_rdata` updates in that cycle; after a write ack it holds its previous value.
- The earliest next accepted request is sampled in the ack cycle itself.
- Reset values: `cfg_ack`=0, `cfg_rdata`=0, `cnt_en_o`=0, `scratch_o`=0, counter=0, shadow=0, ovl_err=0, state IDLE.
- `sync_rst` asserted mid-WAIT discards the pending ack; no ack is issued after reset deasserts.

## Configuration
- `CL_CFG_REG_SLV_CNT_EN` defined: the 64-bit counter, the shadow register and CTRL[1:0] are implemented as described.
- Not defined: counter and shadow are not built. CNT_LO and CNT_HI read 32'hDEAD_BEEF. CTRL[1:0] are ignored on write, read 0, and `cnt_en_o` is tied 0. All other behaviour is unchanged.

## Test plan
- Reset then read ID with `ACK_DLY`=2: `rd` at T -> `cfg_ack` at T+2 only, `cfg_rdata`=32'hC0FF_EE01.
- Write SCRATCH=32'h1234_5678, then read it back -> `scratch_o`=32'h1234_5678 from T+1; readback matches; exactly one ack per request.
- Counter atomicity (macro defined):
  - CTRL=1, with the counter forced near 32'hFFFF_FFF0 in the low word; read CNT_LO, wait 40 cycles, read CNT_HI -> {HI,LO} equals the counter at the CNT_LO sample, even though the low word wrapped.
  - CTRL=3 -> counter reads small (< `ACK_DLY`+4).
- Overlap: issue `rd` at T and `wr` at T+1 (in WAIT) -> one ack at T+2, the write is not applied, STATUS[15:8]=1.
- Simultaneous `wr`+`rd` to SCRATCH -> write applied, STATUS[15:8] increments by 1, one ack.
  - 300 collisions -> STATUS[15:8]=8'hFF.
  - Write STATUS -> STATUS[15:8]=0.
- Unmapped offset 0x3C read -> 32'hDEAD_BEEF with ack.
- Assert `sync_rst` between request and ack -> no ack is ever seen; all outputs are 0.
